// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, active-low syncs, active-video flag, frame tick.
// Optional macro VGA_TIMING_PIPE_ALIGN_EN delays hs/vs by PIPE_DELAY clocks.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hc_reg, hc_next;
  logic [9:0] vc_reg, vc_next;
  logic       blank_reg, blank_next;
  logic       hs_reg, hs_next;
  logic       vs_reg, vs_next;
  logic       frame_done_reg, frame_done_next;
  logic [7:0] frame_count_reg, frame_count_next;

  // Decode is taken from the next-state counters so every registered output
  // describes the same pixel as DrawX/DrawY in the same cycle.
  always_comb begin
    hc_next = hc_reg + 10'd1;
    vc_next = vc_reg;
    if (hc_reg == H_LAST) begin
      hc_next = '0;
      vc_next = (vc_reg == V_LAST) ? '0 : vc_reg + 10'd1;
    end
    blank_next       = (hc_next < H_VIS) && (vc_next < V_VIS);
    hs_next          = !((hc_next >= H_SYNC_START) && (hc_next < H_SYNC_END));
    vs_next          = !((vc_next >= V_SYNC_START) && (vc_next < V_SYNC_END));
    frame_done_next  = (hc_next == '0) && (vc_next == V_VIS);
    frame_count_next = frame_done_next ? frame_count_reg + 8'd1 : frame_count_reg;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_reg          <= '0;
      vc_reg          <= '0;
      blank_reg       <= 1'b0;
      hs_reg          <= 1'b1;
      vs_reg          <= 1'b1;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      hc_reg          <= hc_next;
      vc_reg          <= vc_next;
      blank_reg       <= blank_next;
      hs_reg          <= hs_next;
      vs_reg          <= vs_next;
      frame_done_reg  <= frame_done_next;
      frame_count_reg <= frame_count_next;
    end
  end

  assign DrawX       = hc_reg;
  assign DrawY       = vc_reg;
  assign blank       = blank_reg;
  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;

`ifdef VGA_TIMING_PIPE_ALIGN_EN
  // Sync delay line matching the drawers' ROM + output register latency.
  logic hs_pipe_reg [PIPE_DELAY];
  logic vs_pipe_reg [PIPE_DELAY];

  for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_sync_pipe
    if (gi == 0) begin : g_first
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_pipe_reg[gi] <= 1'b1;
          vs_pipe_reg[gi] <= 1'b1;
        end else begin
          hs_pipe_reg[gi] <= hs_reg;
          vs_pipe_reg[gi] <= vs_reg;
        end
      end
    end else begin : g_rest
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_pipe_reg[gi] <= 1'b1;
          vs_pipe_reg[gi] <= 1'b1;
        end else begin
          hs_pipe_reg[gi] <= hs_pipe_reg[gi-1];
          vs_pipe_reg[gi] <= vs_pipe_reg[gi-1];
        end
      end
    end
  end

  assign hs = hs_pipe_reg[PIPE_DELAY-1];
  assign vs = vs_pipe_reg[PIPE_DELAY-1];
`else
  assign hs = hs_reg;
  assign vs = vs_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line timing and reset,
// reduced-parameter instance for frame/vsync/frame-counter behaviour.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIPE_ALIGN_EN
  localparam int PD = 2;
`else
  localparam int PD = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic [9:0] x_a, y_a, x_b, y_b;
  logic       blank_a, hs_a, vs_a, fd_a;
  logic       blank_b, hs_b, vs_b, fd_b;
  logic [7:0] fc_a, fc_b;

  vga_timing_gen u_full (
    .vga_clk(clk), .reset_n(rst_a), .DrawX(x_a), .DrawY(y_a), .blank(blank_a),
    .hs(hs_a), .vs(vs_a), .frame_done(fd_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .PIPE_DELAY(2)
  ) u_small (
    .vga_clk(clk), .reset_n(rst_b), .DrawX(x_b), .DrawY(y_b), .blank(blank_b),
    .hs(hs_b), .vs(vs_b), .frame_done(fd_b), .frame_count(fc_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Clock edges seen since each instance left reset.
  int t_a = 0;
  int t_b = 0;
  always @(posedge clk or negedge rst_a) if (!rst_a) t_a <= 0; else t_a <= t_a + 1;
  always @(posedge clk or negedge rst_b) if (!rst_b) t_b <= 0; else t_b <= t_b + 1;

  typedef struct packed { int x; int y; int blank; int hs; int vs; int fd; int fc; } exp_t;

  // Raster position is simply elapsed clocks folded by line and frame length.
  function automatic exp_t model(input int t, input int hv, input int hf, input int hsw,
                                 input int hb, input int vv, input int vf, input int vsw,
                                 input int vb);
    exp_t e;
    int ht, vt, ft, s, sx, sy;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    ft = ht * vt;
    e.x = t % ht;
    e.y = (t / ht) % vt;
    e.blank = (t > 0 && e.x < hv && e.y < vv) ? 1 : 0;
    s = t - PD;
    if (s < 0) begin
      e.hs = 1;
      e.vs = 1;
    end else begin
      sx = s % ht;
      sy = (s / ht) % vt;
      e.hs = (sx >= hv + hf && sx < hv + hf + hsw) ? 0 : 1;
      e.vs = (sy >= vv + vf && sy < vv + vf + vsw) ? 0 : 1;
    end
    e.fd = (t > 0 && e.x == 0 && e.y == vv) ? 1 : 0;
    e.fc = (t < vv * ht) ? 0 : (((t - vv * ht) / ft) + 1) % 256;
    return e;
  endfunction

  bit run_a = 0;
  int hs_low_a = 0, first_a = -1, last_a = -1, blank_low_a = 0;
  int hs_low_b = 0, first_b = -1, last_b = -1;
  int bl0 = 0, bl1 = 0, vs1 = 0, vs_first_y = -1, pulses = 0;
  int fc_seen [300];

  // Single compare process: both instances against the model every cycle.
  always @(negedge clk) begin
    exp_t ea, eb;
    ea = model(t_a, 640, 16, 96, 48, 480, 10, 2, 33);
    chk("full_DrawX", int'(x_a), ea.x);
    chk("full_DrawY", int'(y_a), ea.y);
    chk("full_blank", int'(blank_a), ea.blank);
    chk("full_hs", int'(hs_a), ea.hs);
    chk("full_vs", int'(vs_a), ea.vs);
    chk("full_frame_done", int'(fd_a), ea.fd);
    chk("full_frame_count", int'(fc_a), ea.fc);
    eb = model(t_b, 8, 1, 2, 1, 4, 1, 1, 1);
    chk("small_DrawX", int'(x_b), eb.x);
    chk("small_DrawY", int'(y_b), eb.y);
    chk("small_blank", int'(blank_b), eb.blank);
    chk("small_hs", int'(hs_b), eb.hs);
    chk("small_vs", int'(vs_b), eb.vs);
    chk("small_frame_done", int'(fd_b), eb.fd);
    chk("small_frame_count", int'(fc_b), eb.fc);

    if (run_a && t_a >= 1 && t_a < 800 + PD && !hs_a) begin
      hs_low_a++;
      if (first_a < 0) first_a = t_a;
      last_a = t_a;
    end
    if (run_a && t_a >= 1 && y_a == 10'd0 && !blank_a) blank_low_a++;

    if (t_b >= 1 && t_b <= 12 + PD && !hs_b) begin
      hs_low_b++;
      if (first_b < 0) first_b = t_b;
      last_b = t_b;
    end
    if (t_b >= 1 && t_b < 84 && blank_b) bl0++;
    if (t_b >= 84 && t_b < 168) begin
      if (blank_b) bl1++;
      if (!vs_b) begin
        vs1++;
        if (vs_first_y < 0) vs_first_y = int'(y_b);
      end
    end
    if (rst_b && fd_b) begin
      pulses++;
      if (pulses < 300) fc_seen[pulses] = int'(fc_b);
      $display("frame tick %0d: DrawX=%0d DrawY=%0d frame_count=%0d",
               pulses, x_b, y_b, fc_b);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_DrawX"}, int'(x_a), 0);
    chk({tag, "_DrawY"}, int'(y_a), 0);
    chk({tag, "_hs"}, int'(hs_a), 1);
    chk({tag, "_vs"}, int'(vs_a), 1);
    chk({tag, "_blank"}, int'(blank_a), 0);
    chk({tag, "_frame_done"}, int'(fd_a), 0);
    chk({tag, "_frame_count"}, int'(fc_a), 0);
  endtask

  initial begin
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_reset_a("hold_reset");

    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    step(1);
    chk("first_edge_DrawX", int'(x_a), 1);
    chk("first_edge_blank", int'(blank_a), 1);
    step(299);
    chk("pre_reset_DrawX", int'(x_a), 300);

    // Asynchronous mid-line reset, checked before any clock edge.
    #1 rst_a = 1'b0;
    #1;
    chk_reset_a("mid_reset");
    @(negedge clk);
    rst_a = 1'b1;
    run_a = 1;

    step(799);
    chk("line_end_DrawX", int'(x_a), 799);
    chk("line_end_DrawY", int'(y_a), 0);
    step(1);
    chk("wrap_DrawX", int'(x_a), 0);
    chk("wrap_DrawY", int'(y_a), 1);
    chk("wrap_blank", int'(blank_a), 1);
    step(PD + 10);
    chk("hs_low_clocks", hs_low_a, 96);
    chk("hs_fall_at", first_a, 656 + PD);
    chk("hs_last_low_at", last_a, 751 + PD);
    chk("blank_low_clocks", blank_low_a, 160);

    for (int i = 0; i < 30000 && t_b < 21575; i++) @(negedge clk);
    chk("small_run_reached", (t_b >= 21575) ? 1 : 0, 1);
    chk("small_hs_low_clocks", hs_low_b, 2);
    chk("small_hs_fall_at", first_b, 9 + PD);
    chk("small_hs_last_low_at", last_b, 10 + PD);
    chk("small_blank_frame0", bl0, 31);
    chk("small_blank_frame1", bl1, 32);
    chk("small_vs_low_clocks", vs1, 12);
    chk("small_vs_line", vs_first_y, 5);
    chk("frame_pulses", pulses, 257);
    chk("fc_after_pulse1", fc_seen[1], 1);
    chk("fc_after_pulse2", fc_seen[2], 2);
    chk("fc_after_pulse255", fc_seen[255], 255);
    chk("fc_after_pulse256", fc_seen[256], 0);
    chk("fc_after_pulse257", fc_seen[257], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480@60 Hz VGA raster for the display path: horizontal/vertical pixel counters, sync pulses, and the active-video qualifier. It sits directly upstream of the sprite/background drawers and feeds their `DrawX`, `DrawY` and `blank` inputs. It also drives `hs`/`vs` to the VGA connector and gives game logic a once-per-frame tick and frame counter.

## Interface

- `H_VISIBLE`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch, in clocks
- `H_SYNC`, 96: hsync pulse width, in clocks
- `H_BACK`, 48: horizontal back porch, in clocks
- `V_VISIBLE`, 480: active lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync pulse width, in lines
- `V_BACK`, 33: vertical back porch, in lines
- `PIPE_DELAY`, 2: extra sync delay stages; used only with `VGA_TIMING_PIPE_ALIGN_EN`

Ports:

- `vga_clk`  in  1: pixel clock (25 MHz); the only clock
- `reset_n`  in  1: asynchronous, active-low reset
- `DrawX`  out  10: current pixel column, 0..H_TOTAL-1
- `DrawY`  out  10: current line, 0..V_TOTAL-1
- `blank`  out  1: 1 = active video (DrawX<H_VISIBLE and DrawY<V_VISIBLE), 0 = blanking
- `hs`  out  1: horizontal sync, active-low
- `vs`  out  1: vertical sync, active-low
- `frame_done`  out  1: one-cycle pulse at the start of vertical blanking
- `frame_count`  out  8: frames completed, wraps modulo 256

Interface decision: one clock; reset is asynchronous and active-low, with ports named `vga_clk` and `reset_n`.

## Operation

- Derived totals:
  - H_TOTAL = sum of the H parameters (800).
  - V_TOTAL = sum of the V parameters (525).
- Horizontal counter `hc`:
  - Increments every `vga_clk`.
  - At H_TOTAL-1 it wraps to 0.
  - On that wrap, the vertical counter `vc` increments.
- Vertical counter `vc`: at V_TOTAL-1, coincident with the `hc` wrap, it wraps to 0.
- Counter state:
  - `DrawX` = `hc`, `DrawY` = `vc`, both registered.
  - Counters are 10-bit; all comparisons are unsigned.
- Sync decode:
  - `hs` = 0 iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - `vs` = 0 iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC, i.e. lines 490..491.
  - `vs` transitions align with the `hc` wrap.
- Registered decode: `hs`, `vs`, `blank` and `frame_done` are registered from the next-state counter values. Every output therefore describes the same (DrawX, DrawY) in the same cycle.
- `frame_done` asserts for exactly one cycle when (DrawX, DrawY) = (0, V_VISIBLE), i.e. (0, 480).
- `frame_count` increments in that same cycle and wraps 255 -> 0.
- Reset values, applied immediately while `reset_n`=0, independent of the clock:
  - DrawX=0, DrawY=0
  - hs=1, vs=1, blank=0
  - frame_done=0, frame_count=0
  - all delay stages = 1
- Mid-frame reset: all state returns to the reset values immediately. There is no partial-frame recovery; the raster restarts from (0,0).

## Timing

- First rising edge after `reset_n` deasserts: DrawX=1, DrawY=0, blank=1.
- Pixel (0,0) of the first frame after reset is therefore blanked. This is accepted.
- Line period: 800 clocks. Frame period: 420,000 clocks.
- Latency from counter state to `hs`/`vs`/`blank`: 0 cycles (same-cycle aligned).
- `blank` falls the cycle DrawX becomes 640 and rises the cycle DrawX becomes 0 on a visible line.
- Downstream drawers carry 2 cycles of ROM-plus-output-register latency. Their RGB for a given DrawX lags by 2 cycles; sync alignment for this is handled under Configuration.

## Configuration

- `VGA_TIMING_PIPE_ALIGN_EN` defined:
  - `hs` and `vs` each pass through PIPE_DELAY additional registers, each reset to 1.
  - This aligns the sync pulses with the drawers' delayed RGB.
  - `DrawX`, `DrawY`, `blank`, `frame_done` and `frame_count` are not delayed.
- `VGA_TIMING_PIPE_ALIGN_EN` not defined: `hs`/`vs` are same-cycle aligned with DrawX/DrawY, and no delay registers exist.

## Test plan

- **Reset:** hold `reset_n`=0 across 5 clocks, then assert it low mid-line at DrawX=300. Outputs must read DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_done=0, frame_count=0 at once, without waiting for a clock edge.
- **Horizontal:** release reset and run one line.
  - hs=0 exactly for DrawX 656..751 (96 clocks).
  - blank=0 from DrawX 640 to 799.
  - DrawX wraps 799 -> 0 and DrawY steps 0 -> 1.
- **Vertical:** run one full frame.
  - vs=0 for exactly 1600 clocks, while DrawY is 490..491.
  - DrawY wraps 524 -> 0.
  - blank=1 count per frame = 307,200 minus 1 for the post-reset pixel (0,0) on the first frame only.
- **Frame tick:** run 257 frames.
  - frame_done pulses once per frame, one cycle wide, at (0,480).
  - frame_count reads 1 after the first frame and wraps 255 -> 0 on the 256th pulse.
- **Pipe align:** with `VGA_TIMING_PIPE_ALIGN_EN` defined and PIPE_DELAY=2, hs falls 2 clocks after DrawX=656 (i.e. at DrawX=658). The vs edge likewise lags by 2 clocks.
- **Reduced parameters:** H_VISIBLE=8, H_FRONT=1, H_SYNC=2, H_BACK=1, V_VISIBLE=4, V_FRONT=1, V_SYNC=1, V_BACK=1.
  - Line = 12 clocks, frame = 84 clocks.
  - hs=0 at DrawX 9..10.
  - vs=0 on line 5.
